// File: rtl/bnn_neuron_accum.sv
// bnn_neuron_accum
// Sums NCHUNK chunk popcounts into one neuron total, compares it against the
// folded batch-norm threshold (optionally sign-flipped) and packs successive
// binary activations LSB-first into NOUT-bit words. Valid/ready on both sides,
// with a single registered output slot.
module bnn_neuron_accum #(
    parameter int PC_W   = 7,
    parameter int NCHUNK = 8,
    parameter int ACC_W  = 10,
    parameter int NOUT   = 16
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iVALID,
    output logic             oREADY,
    input  logic [PC_W-1:0]  iPOPCNT,
    input  logic [ACC_W-1:0] iTHRESH,
    input  logic             iFLIP,
    input  logic             iFLUSH,
    output logic             oVALID,
    input  logic             iREADY,
    output logic [NOUT-1:0]  oDATA
);

    localparam int CC_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int BC_W = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam logic [CC_W-1:0] LAST_CHUNK = CC_W'(NCHUNK - 1);
    localparam logic [BC_W-1:0] LAST_BIT   = BC_W'(NOUT - 1);

    logic [ACC_W-1:0] acc;
    logic [CC_W-1:0]  chunk_cnt;
    logic [BC_W-1:0]  bit_cnt;
    logic [NOUT-1:0]  pack;

    logic             accept;
    logic             is_final;
    logic [ACC_W-1:0] sum;
    logic             act;
    logic             word_done;
    logic [NOUT-1:0]  new_word;

    // A full output slot that is not being drained blocks the whole pipe.
    assign oREADY    = !oVALID || iREADY;
    assign accept    = iVALID && oREADY;
    assign is_final  = (chunk_cnt == LAST_CHUNK);
    assign sum       = acc + ACC_W'(iPOPCNT);
    assign act       = (sum >= iTHRESH) ^ iFLIP;
    assign word_done = accept && is_final && ((bit_cnt == LAST_BIT) || iFLUSH);

    // Current partial word with this neuron's activation inserted; bits above
    // bit_cnt are already zero because pack is cleared whenever a word leaves.
    always_comb begin
        new_word          = pack;
        new_word[bit_cnt] = act;
    end

    // Chunk accumulation and neuron boundary bookkeeping.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            acc       <= '0;
            chunk_cnt <= '0;
        end else if (accept) begin
            if (is_final) begin
                acc       <= '0;
                chunk_cnt <= '0;
            end else begin
                acc       <= sum;
                chunk_cnt <= chunk_cnt + CC_W'(1);
            end
        end
    end

    // Activation packing; a flush or a full word restarts packing at bit 0.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            pack    <= '0;
            bit_cnt <= '0;
        end else if (accept && is_final) begin
            if (word_done) begin
                pack    <= '0;
                bit_cnt <= '0;
            end else begin
                pack    <= new_word;
                bit_cnt <= bit_cnt + BC_W'(1);
            end
        end
    end

    // One-deep output register; a new word may replace a consumed one in the
    // same cycle so back-to-back words leave without a bubble.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oVALID <= 1'b0;
            oDATA  <= '0;
        end else if (word_done) begin
            oVALID <= 1'b1;
            oDATA  <= new_word;
        end else if (oVALID && iREADY) begin
            oVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bnn_neuron_accum.sv
// tb_bnn_neuron_accum
// Directed stimulus with hand-computed expected words pushed to a scoreboard
// queue; an independent monitor pops and compares on every output handshake.
module tb_bnn_neuron_accum;

    localparam int PC_W   = 7;
    localparam int NCHUNK = 8;
    localparam int ACC_W  = 10;
    localparam int NOUT   = 16;

    logic             iCLK = 1'b0;
    logic             iRST;
    logic             iVALID;
    logic             oREADY;
    logic [PC_W-1:0]  iPOPCNT;
    logic [ACC_W-1:0] iTHRESH;
    logic             iFLIP;
    logic             iFLUSH;
    logic             oVALID;
    logic             iREADY;
    logic [NOUT-1:0]  oDATA;

    int n_checks = 0;
    int n_fail   = 0;
    logic [NOUT-1:0] exp_q[$];

    bnn_neuron_accum #(.PC_W(PC_W), .NCHUNK(NCHUNK), .ACC_W(ACC_W), .NOUT(NOUT)) dut (
        .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .oREADY(oREADY),
        .iPOPCNT(iPOPCNT), .iTHRESH(iTHRESH), .iFLIP(iFLIP), .iFLUSH(iFLUSH),
        .oVALID(oVALID), .iREADY(iREADY), .oDATA(oDATA)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Scoreboard monitor: each output handshake consumes one expected word.
    always @(negedge iCLK) begin
        if (!iRST && oVALID && iREADY) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word got=%0h want=none", oDATA);
            end else begin
                chk("word", 32'(oDATA), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic idle();
        iVALID  = 1'b0;
        iFLUSH  = 1'b0;
        iFLIP   = 1'b0;
        iPOPCNT = '0;
    endtask

    // Offer one beat and return 1 time unit after the edge that accepted it.
    task automatic send_beat(input int pc, input int th, input bit flip, input bit flush);
        bit done;
        done    = 1'b0;
        iVALID  = 1'b1;
        iPOPCNT = PC_W'(pc);
        iTHRESH = ACC_W'(th);
        iFLIP   = flip;
        iFLUSH  = flush;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge iCLK);
            if (oREADY) begin
                @(posedge iCLK);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout got=stalled want=accepted");
        end
    endtask

    // One neuron: sum split into chunks of at most 112. Non-final chunks carry
    // deliberately wrong threshold/flip/flush values, which must be ignored.
    task automatic send_neuron(input int total, input int th, input bit flip, input bit flush);
        int rem;
        int pc;
        rem = total;
        for (int c = 0; c < NCHUNK; c++) begin
            pc  = (rem > 112) ? 112 : rem;
            rem = rem - pc;
            if (c == NCHUNK - 1) send_beat(pc, th, flip, flush);
            else                 send_beat(pc, ~th & 1023, ~flip, 1'b1);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge iCLK);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    initial begin
        iRST    = 1'b1;
        iREADY  = 1'b1;
        iTHRESH = '0;
        idle();
        repeat (3) @(posedge iCLK);
        #1;
        chk("reset_ovalid", 32'(oVALID), 32'd0);
        chk("reset_odata",  32'(oDATA),  32'd0);
        chk("reset_oready", 32'(oREADY), 32'd1);
        iRST = 1'b0;

        // Test 1: all 112, threshold 896 -> all ones; latency of one cycle.
        exp_q.push_back(16'hFFFF);
        for (int n = 0; n < 15; n++) send_neuron(896, 896, 1'b0, 1'b0);
        for (int c = 0; c < NCHUNK - 1; c++) send_beat(112, 0, 1'b1, 1'b1);
        chk("t1_before_last", 32'(oVALID), 32'd0);
        send_beat(112, 896, 1'b0, 1'b0);
        chk("t1_latency", 32'(oVALID), 32'd1);
        idle();
        drain();

        // Test 2: alternating 448/447 against threshold 448.
        exp_q.push_back(16'h5555);
        for (int n = 0; n < 16; n++) send_neuron((n % 2 == 0) ? 448 : 447, 448, 1'b0, 1'b0);
        idle();
        drain();
        repeat (3) @(posedge iCLK);
        #1;
        chk("hold_ovalid", 32'(oVALID), 32'd0);
        chk("hold_odata",  32'(oDATA),  32'h5555);

        // Test 3: flipped -> zeros; zero threshold -> ones.
        exp_q.push_back(16'h0000);
        for (int n = 0; n < 16; n++) send_neuron(896, 896, 1'b1, 1'b0);
        exp_q.push_back(16'hFFFF);
        for (int n = 0; n < 16; n++) send_neuron(0, 0, 1'b0, 1'b0);
        idle();
        drain();

        // Test 4: output stall blocks input; stream resumes intact.
        iREADY = 1'b0;
        exp_q.push_back(16'hFFFF);
        for (int n = 0; n < 16; n++) send_neuron(896, 896, 1'b0, 1'b0);
        exp_q.push_back(16'hFF00);
        fork
            begin
                repeat (6) begin
                    @(negedge iCLK);
                    chk("stall_oready", 32'(oREADY), 32'd0);
                    chk("stall_ovalid", 32'(oVALID), 32'd1);
                    chk("stall_odata",  32'(oDATA),  32'hFFFF);
                end
                @(posedge iCLK);
                #1;
                iREADY = 1'b1;
            end
            begin
                for (int n = 0; n < 16; n++) send_neuron((n < 8) ? 895 : 896, 896, 1'b0, 1'b0);
            end
        join
        idle();
        drain();

        // Test 5: flush of a partial word, then restart at bit 0; flush on a
        // full word produces exactly one word.
        exp_q.push_back(16'h0005);
        send_neuron(896, 896, 1'b0, 1'b0);
        send_neuron(0,   896, 1'b0, 1'b0);
        send_neuron(896, 896, 1'b0, 1'b1);
        exp_q.push_back(16'h0001);
        send_neuron(896, 896, 1'b0, 1'b1);
        exp_q.push_back(16'hAAAA);
        for (int n = 0; n < 16; n++) send_neuron((n % 2 == 1) ? 896 : 0, 896, 1'b0, n == 15);
        exp_q.push_back(16'h0001);
        send_neuron(896, 896, 1'b0, 1'b1);
        idle();
        drain();

        // Test 6: reset mid-neuron discards the partial sum.
        for (int c = 0; c < 5; c++) send_beat(112, 0, 1'b0, 1'b0);
        idle();
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        chk("t6_reset_odata", 32'(oDATA), 32'd0);
        send_neuron(0, 1, 1'b0, 1'b0);
        idle();
        repeat (3) begin
            @(negedge iCLK);
            chk("t6_no_word", 32'(oVALID), 32'd0);
        end
        exp_q.push_back(16'h0002);
        send_neuron(896, 1, 1'b0, 1'b1);
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
